// File: rtl/prog_loader.sv
// prog_loader: UART program loader that writes received bytes into program memory.
// Ports: clk_i/reset_i (async, active-high); p_programm_i arms loading on its
//   rising edge; rx_i carries 8N1 frames (8E1 when PROG_LOADER_PARITY_EN is defined).
//   mem_we_o/mem_addr_o/mem_data_o form the memory write port. cpu_halt_o holds the
//   core while loading. done_o pulses on the last write. frame_err_o is a sticky error.
module prog_loader #(
  parameter int CLKS_PER_BIT         = 434,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int INSTR_WIDTH          = 7
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            p_programm_i,
  input  logic                            rx_i,
  output logic                            mem_we_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [INSTR_WIDTH-1:0]          mem_data_o,
  output logic                            cpu_halt_o,
  output logic                            done_o,
  output logic                            frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int AW = MEMORY_ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    L_OFF, L_ARMED, L_FULL
  } ld_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA,
`ifdef PROG_LOADER_PARITY_EN
    R_PARITY,
`endif
    R_STOP
  } rx_t;

  ld_t                   ld_q, ld_d;
  rx_t                   rs_q, rs_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            sh_q, sh_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  prog_q, rx_q;
`ifdef PROG_LOADER_PARITY_EN
  logic                  perr_q, perr_d;
`endif

  logic p_rise, p_fall, rx_fall, run, bad;

  assign p_rise  = p_programm_i & ~prog_q;
  assign p_fall  = ~p_programm_i & prog_q;
  // A start needs a real high->low transition, so a line still held low
  // after a bad stop bit cannot retrigger the receiver.
  assign rx_fall = rx_q & ~rx_i;
  assign run     = (ld_q == L_ARMED) & ~p_fall;

`ifdef PROG_LOADER_PARITY_EN
  assign bad = ~rx_i | perr_q;
`else
  assign bad = ~rx_i;
`endif

  always_comb begin
    ld_d   = ld_q;
    rs_d   = rs_q;
    cnt_d  = cnt_q + CW'(1);
    bit_d  = bit_q;
    sh_d   = sh_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d   = 1'b0;
    err_d  = err_q;
`ifdef PROG_LOADER_PARITY_EN
    perr_d = perr_q;
`endif

    unique case (ld_q)
      L_OFF: begin
        if (p_rise) begin
          ld_d   = L_ARMED;
          addr_d = '0;
          err_d  = 1'b0;
        end
      end
      L_ARMED: begin
        if (we_q) begin
          if (addr_q == '1) ld_d = L_FULL;
          else addr_d = addr_q + AW'(1);
        end
      end
      L_FULL: ;
      default: ld_d = L_OFF;
    endcase
    if (p_fall) ld_d = L_OFF;

    if (!run) begin
      rs_d  = R_IDLE;
      cnt_d = '0;
    end else begin
      unique case (rs_q)
        R_IDLE: begin
          cnt_d = '0;
          if (rx_fall) rs_d = R_START;
        end
        R_START: begin
          if (cnt_q == C_HALF) begin
            cnt_d = '0;
            bit_d = '0;
            rs_d  = rx_i ? R_IDLE : R_DATA;
          end
        end
        R_DATA: begin
          if (cnt_q == C_FULL) begin
            cnt_d = '0;
            sh_d  = {rx_i, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef PROG_LOADER_PARITY_EN
              rs_d = R_PARITY;
`else
              rs_d = R_STOP;
`endif
            end
          end
        end
`ifdef PROG_LOADER_PARITY_EN
        R_PARITY: begin
          if (cnt_q == C_FULL) begin
            cnt_d  = '0;
            perr_d = ^{sh_q, rx_i};
            rs_d   = R_STOP;
          end
        end
`endif
        R_STOP: begin
          if (cnt_q == C_FULL) begin
            cnt_d = '0;
            rs_d  = R_IDLE;
            if (bad) begin
              err_d = 1'b1;
            end else begin
              we_d   = 1'b1;
              data_d = sh_q[INSTR_WIDTH-1:0];
            end
          end
        end
        default: rs_d = R_IDLE;
      endcase
    end

    done_d = we_d & (addr_q == '1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ld_q   <= L_OFF;
      rs_q   <= R_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Treat programming as already high so a level held through
      // reset is not mistaken for a fresh request.
      prog_q <= 1'b1;
      rx_q   <= 1'b1;
`ifdef PROG_LOADER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      ld_q   <= ld_d;
      rs_q   <= rs_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
      done_q <= done_d;
      err_q  <= err_d;
      prog_q <= p_programm_i;
      rx_q   <= rx_i;
`ifdef PROG_LOADER_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign done_o      = done_q;
  assign frame_err_o = err_q;
  assign cpu_halt_o  = (ld_q != L_OFF);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader
// against a byte-level model of the loader.
module tb_prog_loader;
  localparam int CPB = 4;
  localparam int AW  = 4;
  localparam int IW  = 7;
  localparam int NW  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, p, rx;
  logic          we, halt, done, ferr;
  logic [AW-1:0] addr;
  logic [IW-1:0] data;

  always #5 clk = ~clk;

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .MEMORY_ADDRESS_WIDTH(AW),
    .INSTR_WIDTH(IW)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .p_programm_i(p),
    .rx_i(rx),
    .mem_we_o(we),
    .mem_addr_o(addr),
    .mem_data_o(data),
    .cpu_halt_o(halt),
    .done_o(done),
    .frame_err_o(ferr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // observed writes
  int unsigned got_a[$];
  int unsigned got_d[$];
  int done_seen = 0;
  int done_bad  = 0;
  int wide      = 0;
  logic we_prev = 1'b0;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      got_a.push_back(int'(addr));
      got_d.push_back(int'(data));
      if (we_prev) wide++;
    end
    if (done === 1'b1) begin
      done_seen++;
      if (!(we === 1'b1 && addr == AW'(NW - 1))) done_bad++;
    end
    we_prev = we;
  end

  // reference model: byte-level behaviour of the loader
  int m_addr  = 0;
  bit m_armed = 0;
  bit m_err   = 0;
  int exp_a[$];
  int exp_d[$];
  int exp_done = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rearm();
    p = 1'b0;
    tick(3);
    p = 1'b1;
    tick(3);
    m_armed = 1;
    m_addr  = 0;
    m_err   = 0;
  endtask

  task automatic send(input logic [7:0] b,
                      input bit stop_ok,
                      input bit par_ok);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
`ifdef PROG_LOADER_PARITY_EN
    rx = (^b) ^ ~par_ok;
    tick(CPB);
`endif
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
    tick(3);
    if (m_armed && m_addr < NW) begin
      if (stop_ok && par_ok) begin
        exp_a.push_back(m_addr);
        exp_d.push_back(int'(b[6:0]));
        if (m_addr == NW - 1) exp_done++;
        m_addr++;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_nwr"}, got_a.size(), exp_a.size());
    n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_a%0d", tag, i), got_a[i], exp_a[i]);
      check($sformatf("%s_d%0d", tag, i), got_d[i], exp_d[i]);
    end
    check({tag, "_done"}, done_seen, exp_done);
    check({tag, "_err"}, ferr, m_err);
    got_a.delete();
    got_d.delete();
    exp_a.delete();
    exp_d.delete();
  endtask

  initial begin
    logic [7:0] b;
    bit         s;
    bit         pk;
    rst = 1'b1;
    p   = 1'b1;
    rx  = 1'b1;
    tick(3);
    check("rst_we", we, 0);
    check("rst_halt", halt, 0);
    check("rst_done", done, 0);
    check("rst_err", ferr, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    rst = 1'b0;
    tick(5);
    check("hold_off", halt, 0);

    // single byte
    rearm();
    check("armed_halt", halt, 1);
    send(8'h5A, 1, 1);
    compare("b5a");
    check("b5a_halt", halt, 1);

    // fill, then overflow byte ignored
    rearm();
    for (int i = 0; i < NW; i++) send(8'(i), 1, 1);
    send(8'h7F, 1, 1);
    compare("fill");
    check("full_halt", halt, 1);

    // bad stop then retry at same address
    rearm();
    send(8'h33, 0, 1);
    send(8'h44, 1, 1);
    compare("ferr");

    // random bytes, random stop errors
    rearm();
    for (int i = 0; i < 10; i++) begin
      b  = 8'($urandom);
      s  = ($urandom_range(0, 4) != 0);
      pk = 1;
      send(b, s, pk);
    end
    compare("rnd");

    rearm();
    check("err_clr", ferr, 0);

    // abort during data bit 3
    b  = 8'h99;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = b[3];
    tick(2);
    p = 1'b0;
    m_armed = 0;
    tick(1);
    check("abort_halt", halt, 0);
    tick(1);
    for (int i = 4; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB + 3);
    compare("abort");
    rearm();
    send(8'h12, 1, 1);
    compare("rearm");

    // glitch on rx
    rearm();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    compare("glitch");

`ifdef PROG_LOADER_PARITY_EN
    rearm();
    send(8'h03, 1, 1);
    send(8'h03, 1, 0);
    compare("par");
`endif

    // reset in the middle of a byte
    rearm();
    send(8'h6B, 1, 1);
    compare("pre_rst");
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB + 1);
    #2 rst = 1'b1;
    #1;
    check("arst_we", we, 0);
    check("arst_halt", halt, 0);
    check("arst_done", done, 0);
    check("arst_err", ferr, 0);
    check("arst_addr", addr, 0);
    check("arst_data", data, 0);
    m_armed = 0;
    rx = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(CPB * 12);
    check("post_rst_halt", halt, 0);
    compare("post_rst");

    check("we_width", wide, 0);
    check("done_align", done_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
